sgf_divider_seq: RTL and testbench

Sequential radix-2 restoring divider for normalized significands. It is the division-direction counterpart of the significand-multiply phase in the floating-point datapath. It registers both significands on a start pulse and produces one quotient bit per clock. It then presents a quotient carrying guard/round bits plus a sticky flag to the downstream normalize/round phase, with a single-cycle done strobe.

---
 rtl/sgf_divider_seq_pkg.sv | 30 +++
 rtl/sgf_divider_seq_div_step.sv | 22 ++
 rtl/sgf_divider_seq.sv | 135 +++++++++++++
 tb/tb_sgf_divider_seq.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sgf_divider_seq_pkg.sv
// Shared definitions for the significand multiply/divide phases:
// FSM state encoding and the widths derived from the stored fraction width.
package sgf_divider_seq_pkg;

    // Sequencer states shared by the multi-cycle significand phases.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } sgf_state_t;

    // Stored fraction width of single precision (52 for double).
    localparam int W_SGF_DEFAULT = 23;

    // Quotient width: hidden bit, fraction, guard and round bits.
    function automatic int q_width(input int w_sgf);
        return w_sgf + 3;
    endfunction

    // Partial remainder width: R < 2D < 4 needs one bit above the hidden bit.
    function automatic int r_width(input int w_sgf);
        return w_sgf + 2;
    endfunction

    // Iteration counter width, large enough to hold q_width().
    function automatic int cnt_width(input int w_sgf);
        return $clog2(w_sgf + 4);
    endfunction

endpackage

// File: rtl/sgf_divider_seq_div_step.sv
// One radix-2 restoring division step: compare the partial remainder with
// the divisor, subtract when it fits, and shift the result left by one.
module sgf_divider_seq_div_step #(
    parameter int W_R = 25
) (
    input  logic [W_R-1:0] r,
    input  logic [W_R-1:0] d,
    output logic           q,
    output logic [W_R-1:0] r_next
);

    logic [W_R-1:0] diff;

    // Restoring step; the top bit dropped by the shift is always zero
    // because the remainder stays below twice the divisor.
    always_comb begin
        diff   = r - d;
        q      = (r >= d);
        r_next = q ? {diff[W_R-2:0], 1'b0} : {r[W_R-2:0], 1'b0};
    end

endmodule

// File: rtl/sgf_divider_seq.sv
// Sequential radix-2 restoring divider for normalized significands.
// Produces one quotient bit per clock; the quotient carries guard/round
// bits and a sticky flag for the following normalize/round phase.
module sgf_divider_seq
    import sgf_divider_seq_pkg::*;
#(
    parameter int W_Sgf = W_SGF_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [W_Sgf:0]     Sgf_X,
    input  logic [W_Sgf:0]     Sgf_Y,
    output logic               busy,
    output logic               done,
    output logic [W_Sgf+2:0]   Q_Sgf,
    output logic               Sticky,
    output logic               Div_Zero
);

    localparam int W_Q   = q_width(W_Sgf);
    localparam int W_R   = r_width(W_Sgf);
    localparam int W_CNT = cnt_width(W_Sgf);

    localparam logic [W_CNT-1:0] N_STEPS = W_CNT'(W_Q);
    localparam logic [W_CNT-1:0] CNT_ONE = W_CNT'(1);

    sgf_state_t       state;
    sgf_state_t       state_next;
    logic [W_R-1:0]   r;
    logic [W_R-1:0]   d;
    logic [W_CNT-1:0] cnt;

    logic             step_q;
    logic [W_R-1:0]   step_r_next;
    logic             y_zero;
    logic             last_step;

    assign y_zero    = (Sgf_Y == '0);
    assign last_step = (state == ITER) && (cnt == CNT_ONE);

    sgf_divider_seq_div_step #(
        .W_R (W_R)
    ) u_div_step (
        .r      (r),
        .d      (d),
        .q      (step_q),
        .r_next (step_r_next)
    );

    // State register; reset wins over everything, aborting any division.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A division by zero enters DONE with done still low
    // and raises it one cycle later; a normal division enters DONE with done
    // already high. Either way DONE is left once done has been shown.
    always_comb begin
        // NOTE: default first so every path assigns state_next (no latch).
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = y_zero ? DONE : ITER;
                end
            end
            ITER: begin
                if (cnt == CNT_ONE) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath and registered outputs: operand capture, one quotient bit per
    // ITER cycle, result flags, and the busy/done handshake.
    always_ff @(posedge clk) begin
        // NOTE: the datapath registers are reset too, so an aborted division
        // leaves no stale remainder, quotient or counter behind.
        if (!rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            Q_Sgf    <= '0;
            Sticky   <= 1'b0;
            Div_Zero <= 1'b0;
            r        <= '0;
            d        <= '0;
            cnt      <= '0;
        end else begin
            busy <= (state_next != IDLE);
            done <= last_step || ((state == DONE) && !done);

            unique case (state)
                IDLE: begin
                    if (start) begin
                        Div_Zero <= y_zero;
                        Sticky   <= 1'b0;
                        if (y_zero) begin
                            Q_Sgf <= '1;
                        end else begin
                            r     <= {1'b0, Sgf_X};
                            d     <= {1'b0, Sgf_Y};
                            Q_Sgf <= '0;
                            cnt   <= N_STEPS;
                        end
                    end
                end
                ITER: begin
                    r     <= step_r_next;
                    Q_Sgf <= {Q_Sgf[W_Q-2:0], step_q};
                    cnt   <= cnt - CNT_ONE;
                    if (last_step) begin
                        Sticky <= |step_r_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sgf_divider_seq.sv
// Self-checking bench for sgf_divider_seq (W_Sgf = 23): expected results are
// queued when a start is issued and compared when done appears.
module tb_sgf_divider_seq;

    localparam int W_SGF = 23;

    typedef struct {
        logic [W_SGF+2:0] q;
        logic             sticky;
        logic             dz;
        int               lat;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             start;
    logic [W_SGF:0]   Sgf_X;
    logic [W_SGF:0]   Sgf_Y;
    logic             busy;
    logic             done;
    logic [W_SGF+2:0] Q_Sgf;
    logic             Sticky;
    logic             Div_Zero;

    int   checks     = 0;
    int   failures   = 0;
    int   cyc        = 0;
    int   accept_cyc = 0;
    exp_t sb[$];

    sgf_divider_seq #(
        .W_Sgf (W_SGF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .Sgf_X    (Sgf_X),
        .Sgf_Y    (Sgf_Y),
        .busy     (busy),
        .done     (done),
        .Q_Sgf    (Q_Sgf),
        .Sticky   (Sticky),
        .Div_Zero (Div_Zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: quotient in units of 2^-25 is floor(X * 2^25 / Y).
    function automatic exp_t model(input logic [W_SGF:0] x, input logic [W_SGF:0] y);
        exp_t   e;
        longint num;
        longint den;
        if (y == '0) begin
            e.q      = '1;
            e.sticky = 1'b0;
            e.dz     = 1'b1;
            e.lat    = 1;
        end else begin
            num      = longint'(x) << (W_SGF + 2);
            den      = longint'(y);
            e.q      = (W_SGF+3)'(num / den);
            e.sticky = ((num % den) != 0);
            e.dz     = 1'b0;
            e.lat    = W_SGF + 3;
        end
        return e;
    endfunction

    // Drive a one-cycle start from a negedge; queue the expected result.
    task automatic issue(input logic [W_SGF:0] x, input logic [W_SGF:0] y, input exp_t e);
        Sgf_X = x;
        Sgf_Y = y;
        start = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1 accept_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        Sgf_X = $urandom();
        Sgf_Y = $urandom();
    endtask

    // Wait (bounded) for done, pop and compare, then check strobe width/hold.
    task automatic wait_result(input string tag);
        exp_t e;
        int   n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            $display("FAIL %s timeout: done=%b after %0d cycles, required 1", tag, done, n);
            failures++;
            return;
        end
        checks++;
        if (sb.size() == 0) begin
            $display("FAIL %s unexpected done: queue empty", tag);
            failures++;
            @(negedge clk);
            return;
        end
        e = sb.pop_front();
        checks++;
        if (Q_Sgf !== e.q) begin
            $display("FAIL %s Q_Sgf: got %h required %h", tag, Q_Sgf, e.q);
            failures++;
        end
        checks++;
        if (Sticky !== e.sticky) begin
            $display("FAIL %s Sticky: got %b required %b", tag, Sticky, e.sticky);
            failures++;
        end
        checks++;
        if (Div_Zero !== e.dz) begin
            $display("FAIL %s Div_Zero: got %b required %b", tag, Div_Zero, e.dz);
            failures++;
        end
        checks++;
        if ((cyc - accept_cyc) !== e.lat) begin
            $display("FAIL %s latency: got %0d required %0d", tag, cyc - accept_cyc, e.lat);
            failures++;
        end
        checks++;
        if (busy !== 1'b1) begin
            $display("FAIL %s busy during done: got %b required 1", tag, busy);
            failures++;
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL %s after done: done=%b busy=%b required 0 0", tag, done, busy);
            failures++;
        end
        checks++;
        if (Q_Sgf !== e.q || Div_Zero !== e.dz || Sticky !== e.sticky) begin
            $display("FAIL %s hold: Q_Sgf=%h required %h", tag, Q_Sgf, e.q);
            failures++;
        end
    endtask

    task automatic check_no_done(input int cycles, input string tag);
        int extra = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done !== 1'b0) extra++;
        end
        checks++;
        if (extra !== 0) begin
            $display("FAIL %s spurious done: got %0d strobes required 0", tag, extra);
            failures++;
        end
    endtask

    task automatic check_idle_zero(input string tag);
        checks++;
        if ({busy, done, Q_Sgf, Sticky, Div_Zero} !== '0) begin
            $display("FAIL %s outputs: busy=%b done=%b Q=%h S=%b DZ=%b required all 0",
                     tag, busy, done, Q_Sgf, Sticky, Div_Zero);
            failures++;
        end
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        start = 1'b0;
        Sgf_X = '0;
        Sgf_Y = '0;
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        rst = 1'b1;
        @(negedge clk);
        check_idle_zero("post_reset");
    endtask

    task automatic test_directed();
        exp_t e;
        e = '{q: 26'h2000000, sticky: 1'b0, dz: 1'b0, lat: 26};
        issue(24'h800000, 24'h800000, e);
        checks++;
        if (busy !== 1'b1) begin
            $display("FAIL busy_after_accept: got %b required 1", busy);
            failures++;
        end
        wait_result("one_by_one");
        e = '{q: 26'h3000000, sticky: 1'b0, dz: 1'b0, lat: 26};
        issue(24'hC00000, 24'h800000, e);
        wait_result("1p5_by_one");
        e = '{q: 26'h1555555, sticky: 1'b1, dz: 1'b0, lat: 26};
        issue(24'h800000, 24'hC00000, e);
        wait_result("one_by_1p5");
        e = '{q: 26'h3FFFFFC, sticky: 1'b0, dz: 1'b0, lat: 26};
        issue(24'hFFFFFF, 24'h800000, e);
        wait_result("max_by_one");
    endtask

    task automatic test_div_zero();
        exp_t e;
        e = '{q: 26'h3FFFFFF, sticky: 1'b0, dz: 1'b1, lat: 1};
        issue(24'hA00000, 24'h000000, e);
        wait_result("div_zero");
        // A following normal division must clear Div_Zero.
        issue(24'h900000, 24'hB00000, model(24'h900000, 24'hB00000));
        wait_result("clear_div_zero");
    endtask

    task automatic test_back_to_back();
        logic [W_SGF:0] x;
        logic [W_SGF:0] y;
        for (int i = 0; i < 4; i++) begin
            x = {1'b1, W_SGF'($urandom())};
            y = {1'b1, W_SGF'($urandom())};
            issue(x, y, model(x, y));
            wait_result("random_b2b");
        end
    endtask

    task automatic test_ignore_start();
        exp_t e;
        e = '{q: 26'h3000000, sticky: 1'b0, dz: 1'b0, lat: 26};
        issue(24'hC00000, 24'h800000, e);
        repeat (4) @(negedge clk);
        Sgf_X = 24'h800000;
        Sgf_Y = 24'hC00000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_result("ignore_start");
        check_no_done(40, "ignore_start");
    endtask

    task automatic test_reset_mid_iter();
        issue(24'h800000, 24'hC00000, model(24'h800000, 24'hC00000));
        repeat (9) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle_zero("reset_mid_iter");
        rst = 1'b1;
        sb.delete();
        check_no_done(40, "reset_mid_iter");
        issue(24'hE00000, 24'h900000, model(24'hE00000, 24'h900000));
        wait_result("after_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_zero();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid_iter();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
